// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage feeding the control unit.
//
// Holds the program counter and fetches 16-bit instruction words from
// instruction memory over a req/ack handshake. The fetched word sits in a
// stable instruction register until the control unit asks for the next one
// (next_instr) or redirects fetch (pc_load).
//
// Parameters:
//   RESET_PC  first fetch address after reset
//   NOP_WORD  instruction register contents while no valid word is held
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   mem_req/mem_addr    fetch request and word address (mem_addr = pc)
//   mem_ack/mem_rdata   memory response, sampled only while mem_req=1
//   instruction         instruction register
//   ir_valid            instruction holds a fetched, non-discarded word
//   ir_pc               address the current instruction came from
//   next_instr          pulse: advance to pc+1
//   pc_load/pc_target   pulse: redirect fetch to pc_target
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_WORD = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] instruction,
  output logic        ir_valid,
  output logic [15:0] ir_pc,
  input  logic        next_instr,
  input  logic        pc_load,
  input  logic [15:0] pc_target
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] ir_pc_q, ir_pc_d;
  logic        redirect_pend_q, redirect_pend_d;
  logic [15:0] redirect_addr_q, redirect_addr_d;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    instr_d         = instr_q;
    ir_pc_d         = ir_pc_q;
    redirect_pend_d = redirect_pend_q;
    redirect_addr_d = redirect_addr_q;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        if (!mem_ack) begin
          // The request cannot be withdrawn, so a redirect is parked until
          // the in-flight word comes back and is thrown away.
          if (pc_load) begin
            redirect_pend_d = 1'b1;
            redirect_addr_d = pc_target;
          end
        end else if (pc_load) begin
          // A same-cycle redirect is newer than any parked one.
          pc_d            = pc_target;
          redirect_pend_d = 1'b0;
        end else if (redirect_pend_q) begin
          pc_d            = redirect_addr_q;
          redirect_pend_d = 1'b0;
        end else begin
          instr_d = mem_rdata;
          ir_pc_d = pc_q;
          state_d = S_HOLD;
        end
      end

      S_HOLD: begin
        if (pc_load) begin
          pc_d    = pc_target;
          instr_d = NOP_WORD;
          state_d = S_FETCH;
        end else if (next_instr) begin
          pc_d    = pc_q + 16'd1;
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      pc_q            <= RESET_PC;
      instr_q         <= NOP_WORD;
      ir_pc_q         <= '0;
      redirect_pend_q <= 1'b0;
      redirect_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      instr_q         <= instr_d;
      ir_pc_q         <= ir_pc_d;
      redirect_pend_q <= redirect_pend_d;
      redirect_addr_q <= redirect_addr_d;
    end
  end

  assign mem_req     = (state_q == S_FETCH);
  assign mem_addr    = pc_q;
  assign instruction = instr_q;
  assign ir_valid    = (state_q == S_HOLD);
  assign ir_pc       = ir_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// sequence of advances/redirects with random memory wait states, checked
// against a transaction-level model (target address, word, latency).
module tb_fetch_unit;

  localparam logic [15:0] RST_PC = 16'h0010;
  localparam logic [15:0] NOP    = 16'h0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] instruction;
  logic        ir_valid;
  logic [15:0] ir_pc;
  logic        next_instr;
  logic        pc_load;
  logic [15:0] pc_target;

  int errors = 0;
  int checks = 0;

  // Memory model: auto mode acks after wait_cfg wait cycles; manual mode
  // drives man_ack directly.
  bit          auto_mem = 1'b1;
  logic        man_ack  = 1'b0;
  int unsigned wait_cfg = 0;
  int unsigned wait_cnt = 0;

  fetch_unit #(
    .RESET_PC (RST_PC),
    .NOP_WORD (NOP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instruction (instruction),
    .ir_valid    (ir_valid),
    .ir_pc       (ir_pc),
    .next_instr  (next_instr),
    .pc_load     (pc_load),
    .pc_target   (pc_target)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memfn(input logic [15:0] a);
    case (a)
      16'h0010: memfn = 16'h2F13;
      16'h0011: memfn = 16'h3701;
      16'h0012: memfn = 16'h3F11;
      16'h0013: memfn = 16'h4807;
      default:  memfn = {a[7:0], a[15:8]} ^ 16'h5A5B;
    endcase
  endfunction

  assign mem_rdata = memfn(mem_addr);
  always_comb mem_ack = auto_mem ? (mem_req && (wait_cnt == wait_cfg)) : man_ack;

  always @(posedge clk) begin
    if (reset || !mem_req || mem_ack) wait_cnt <= 0;
    else                              wait_cnt <= wait_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; next_instr = 1'b0; pc_load = 1'b0; pc_target = '0;
    auto_mem = 1'b1; man_ack = 1'b0; wait_cfg = 0;
    tick(); tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", mem_req); end
    checks++; if (mem_addr !== RST_PC) begin errors++; $display("FAIL rst_addr: got %h want %h", mem_addr, RST_PC); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", ir_valid); end
    checks++; if (instruction !== NOP) begin errors++; $display("FAIL rst_instr: got %h want %h", instruction, NOP); end
    checks++; if (ir_pc !== 16'h0000) begin errors++; $display("FAIL rst_irpc: got %h want 0000", ir_pc); end
    reset = 1'b0;
    tick();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", mem_req); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL first_valid0: got %b want 0", ir_valid); end
    tick();
    checks++; if (instruction !== 16'h2F13) begin errors++; $display("FAIL first_instr: got %h want 2f13", instruction); end
    checks++; if (ir_pc !== RST_PC) begin errors++; $display("FAIL first_irpc: got %h want %h", ir_pc, RST_PC); end
    checks++; if (ir_valid !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL first_hold: got valid=%b req=%b want 1/0", ir_valid, mem_req); end
  endtask

  task automatic test_sequential();
    logic [15:0] words [3] = '{16'h3701, 16'h3F11, 16'h4807};
    logic [15:0] a;
    for (int i = 0; i < 3; i++) begin
      a = RST_PC + 16'(i + 1);
      next_instr = 1'b1; tick(); next_instr = 1'b0;
      checks++; if (mem_req !== 1'b1 || mem_addr !== a) begin errors++; $display("FAIL seq_req%0d: got req=%b addr=%h want 1/%h", i, mem_req, mem_addr, a); end
      checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL seq_bubble%0d: got %b want 0", i, ir_valid); end
      tick();
      checks++; if (ir_valid !== 1'b1 || instruction !== words[i] || ir_pc !== a) begin
        errors++; $display("FAIL seq_load%0d: got v=%b i=%h pc=%h want 1/%h/%h", i, ir_valid, instruction, ir_pc, words[i], a);
      end
    end
    tick();
    checks++; if (ir_valid !== 1'b1 || mem_req !== 1'b0 || instruction !== 16'h4807) begin
      errors++; $display("FAIL seq_idlehold: got v=%b req=%b i=%h want 1/0/4807", ir_valid, mem_req, instruction);
    end
  endtask

  task automatic test_redirect_in_flight();
    wait_cfg = 3;
    next_instr = 1'b1; tick(); next_instr = 1'b0;
    checks++; if (mem_addr !== 16'h0014 || mem_req !== 1'b1) begin errors++; $display("FAIL rd_req: got req=%b addr=%h want 1/0014", mem_req, mem_addr); end
    pc_load = 1'b1; pc_target = 16'h0200; tick(); pc_load = 1'b0;
    checks++; if (mem_addr !== 16'h0014 || mem_req !== 1'b1) begin errors++; $display("FAIL rd_stable: got req=%b addr=%h want 1/0014", mem_req, mem_addr); end
    tick(); tick(); tick();
    checks++; if (mem_addr !== 16'h0200 || ir_valid !== 1'b0 || instruction !== 16'h4807) begin
      errors++; $display("FAIL rd_discard: got addr=%h v=%b i=%h want 0200/0/4807", mem_addr, ir_valid, instruction);
    end
    for (int c = 0; c < 4; c++) begin
      checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0200 || ir_valid !== 1'b0) begin
        errors++; $display("FAIL rd_wait%0d: got req=%b addr=%h v=%b want 1/0200/0", c, mem_req, mem_addr, ir_valid);
      end
      tick();
    end
    checks++; if (ir_valid !== 1'b1 || ir_pc !== 16'h0200 || instruction !== memfn(16'h0200)) begin
      errors++; $display("FAIL rd_load: got v=%b pc=%h i=%h want 1/0200/%h", ir_valid, ir_pc, instruction, memfn(16'h0200));
    end
  endtask

  task automatic test_wait_states();
    wait_cfg = 3;
    next_instr = 1'b1; tick(); next_instr = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0201 || ir_valid !== 1'b0) begin
        errors++; $display("FAIL ws_wait%0d: got req=%b addr=%h v=%b want 1/0201/0", c, mem_req, mem_addr, ir_valid);
      end
      tick();
    end
    checks++; if (ir_valid !== 1'b1 || ir_pc !== 16'h0201 || instruction !== memfn(16'h0201)) begin
      errors++; $display("FAIL ws_load: got v=%b pc=%h i=%h want 1/0201/%h", ir_valid, ir_pc, instruction, memfn(16'h0201));
    end
  endtask

  task automatic test_load_priority();
    wait_cfg = 0;
    next_instr = 1'b1; pc_load = 1'b1; pc_target = 16'h0300; tick();
    next_instr = 1'b0; pc_load = 1'b0;
    checks++; if (mem_addr !== 16'h0300 || instruction !== NOP || ir_valid !== 1'b0) begin
      errors++; $display("FAIL prio_req: got addr=%h i=%h v=%b want 0300/%h/0", mem_addr, instruction, ir_valid, NOP);
    end
    tick();
    checks++; if (ir_pc !== 16'h0300 || ir_valid !== 1'b1) begin errors++; $display("FAIL prio_load: got pc=%h v=%b want 0300/1", ir_pc, ir_valid); end
  endtask

  task automatic test_wrap();
    wait_cfg = 0;
    pc_load = 1'b1; pc_target = 16'hFFFF; tick(); pc_load = 1'b0;
    tick();
    checks++; if (ir_pc !== 16'hFFFF) begin errors++; $display("FAIL wrap_top: got %h want ffff", ir_pc); end
    next_instr = 1'b1; tick(); next_instr = 1'b0;
    checks++; if (mem_addr !== 16'h0000 || mem_req !== 1'b1) begin errors++; $display("FAIL wrap_addr: got req=%b addr=%h want 1/0000", mem_req, mem_addr); end
    tick();
    checks++; if (ir_pc !== 16'h0000 || instruction !== memfn(16'h0000)) begin
      errors++; $display("FAIL wrap_load: got pc=%h i=%h want 0000/%h", ir_pc, instruction, memfn(16'h0000));
    end
  endtask

  task automatic test_reset_mid_fetch();
    auto_mem = 1'b0; man_ack = 1'b0;
    next_instr = 1'b1; tick(); next_instr = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0001) begin errors++; $display("FAIL rmf_req: got req=%b addr=%h want 1/0001", mem_req, mem_addr); end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (mem_req !== 1'b0 || mem_addr !== RST_PC || ir_valid !== 1'b0) begin
      errors++; $display("FAIL rmf_reset: got req=%b addr=%h v=%b want 0/%h/0", mem_req, mem_addr, ir_valid, RST_PC);
    end
    man_ack = 1'b1; tick(); man_ack = 1'b0;
    checks++; if (ir_valid !== 1'b0 || instruction !== NOP || mem_req !== 1'b1 || mem_addr !== RST_PC) begin
      errors++; $display("FAIL rmf_stale: got v=%b i=%h req=%b addr=%h want 0/%h/1/%h", ir_valid, instruction, mem_req, mem_addr, NOP, RST_PC);
    end
    auto_mem = 1'b1; wait_cfg = 0;
    tick();
    checks++; if (ir_valid !== 1'b1 || instruction !== 16'h2F13 || ir_pc !== RST_PC) begin
      errors++; $display("FAIL rmf_refetch: got v=%b i=%h pc=%h want 1/2f13/%h", ir_valid, instruction, ir_pc, RST_PC);
    end
  endtask

  // Model: each HOLD-state request names one target (load beats advance);
  // an optional redirect during the fetch replaces it and costs a second
  // full fetch of the same wait length.
  task automatic test_random();
    logic [15:0] cur, tgt, t2, exp_addr;
    int unsigned op, k, exp_cycles;
    bit mid;
    int c;
    cur = RST_PC;
    for (int it = 0; it < 40; it++) begin
      wait_cfg = $urandom_range(0, 3);
      op  = $urandom_range(0, 2);
      tgt = 16'($urandom);
      t2  = 16'($urandom);
      mid = 1'($urandom_range(0, 1));
      k   = $urandom_range(0, wait_cfg);
      exp_addr   = (op == 0) ? cur + 16'd1 : tgt;
      exp_cycles = wait_cfg + 1;
      if (mid) begin
        exp_addr   = t2;
        exp_cycles = 2 * (wait_cfg + 1);
      end
      next_instr = (op != 1); pc_load = (op != 0); pc_target = tgt;
      tick();
      next_instr = 1'b0; pc_load = 1'b0;
      c = 0;
      while (!ir_valid && c < 60) begin
        if (mid && c == int'(k)) begin pc_load = 1'b1; pc_target = t2; end
        tick();
        pc_load = 1'b0;
        c++;
      end
      checks++; if (ir_valid !== 1'b1 || c != int'(exp_cycles)) begin
        errors++; $display("FAIL rnd_latency%0d: got v=%b cycles=%0d want 1/%0d", it, ir_valid, c, exp_cycles);
      end
      checks++; if (ir_pc !== exp_addr || instruction !== memfn(exp_addr)) begin
        errors++; $display("FAIL rnd_word%0d: got pc=%h i=%h want %h/%h", it, ir_pc, instruction, exp_addr, memfn(exp_addr));
      end
      cur = exp_addr;
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect_in_flight();
    test_wait_states();
    test_load_priority();
    test_wrap();
    test_reset_mid_fetch();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the control unit. Holds the program counter, fetches 16-bit instruction words from instruction memory over a req/ack handshake, and presents them on a stable instruction register to the control unit. Advances sequentially on the control unit's `next_instr` request, or redirects to a target on `pc_load` (jmpl, ba, call). Redirects arriving while a fetch is in flight are handled safely.

## Interface
- `RESET_PC`, 16'h0000, address of the first instruction fetched after reset
- `NOP_WORD`, 16'h0000, value held in the instruction register while no valid instruction is present

- `clk`  in  1  rising-edge clock; the only clock
- `reset`  in  1  synchronous, active-high reset
- `mem_req`  out  1  fetch request to instruction memory
- `mem_addr`  out  16  fetch address, word-addressed
- `mem_ack`  in  1  memory has `mem_rdata` valid this cycle; sampled only while `mem_req`=1
- `mem_rdata`  in  16  instruction word returned by memory
- `instruction`  out  16  instruction register, driving the control unit's instruction input
- `ir_valid`  out  1  `instruction` holds a fetched, non-discarded word
- `ir_pc`  out  16  address `instruction` was fetched from, used as the link value for call/jmpl
- `next_instr`  in  1  single-cycle pulse from the control unit: current instruction finished, advance
- `pc_load`  in  1  single-cycle pulse: redirect fetch to `pc_target`
- `pc_target`  in  16  redirect address, sampled when `pc_load`=1

## Operation
- Registers:
  - `pc`: next fetch address
  - `instruction`
  - `ir_pc`
  - `redirect_pend`: 1 bit
  - `redirect_addr`: 16 bits
  - `state`: IDLE, FETCH or HOLD
- Outputs: `mem_addr` = `pc`; `mem_req` = (`state`==FETCH).
- IDLE: entered on reset. Go to FETCH unconditionally on the next edge.
- FETCH, `mem_ack`=0:
  - stay in FETCH; `mem_req` and `mem_addr` stay stable until ack (no request withdrawal).
  - `pc_load`=1: set `redirect_pend`=1 and `redirect_addr`=`pc_target`.
- FETCH, `mem_ack`=1, no redirect pending and `pc_load`=0:
  - `instruction`←`mem_rdata`, `ir_pc`←`pc`, `ir_valid`←1.
  - Go to HOLD. `pc` is unchanged.
- FETCH, `mem_ack`=1, with `redirect_pend`=1 or `pc_load`=1 in the same cycle:
  - discard `mem_rdata`; `pc`←redirect address, where a same-cycle `pc_load` wins over `redirect_addr`.
  - clear `redirect_pend`; stay in FETCH and issue a new request next cycle.
  - `ir_valid` stays 0.
- HOLD, `pc_load`=1:
  - `pc`←`pc_target`; `ir_valid`←0; `instruction`←`NOP_WORD`; go to FETCH.
  - `pc_load` has priority over `next_instr` when both are high in the same cycle.
- HOLD, `next_instr`=1, `pc_load`=0:
  - `pc`←`pc`+1, modulo 2^16 (16'hFFFF wraps to 16'h0000).
  - `ir_valid`←0; go to FETCH.
  - `instruction` keeps the old word until the new one is loaded.
- HOLD, neither input high: hold all registers.
- `next_instr` outside HOLD is ignored.
- `pc_load` in IDLE is ignored.
- `ir_valid`=1 exactly when `state`==HOLD.

## Timing
- Reset is synchronous. Values after the reset edge:
  - `state`=IDLE, `pc`=`RESET_PC`
  - `instruction`=`NOP_WORD`, `ir_pc`=16'h0000, `ir_valid`=0
  - `mem_req`=0, `redirect_pend`=0
- Reset mid-fetch drops the outstanding request. A late `mem_ack` while in IDLE is ignored.
- `mem_req` first rises one cycle after `reset` deasserts (IDLE→FETCH).
- `mem_ack` may arrive in the same cycle `mem_req` rises (zero-wait memory). The IR loads on that edge and `ir_valid`=1 in the following cycle.
- With zero-wait memory:
  - `next_instr` at edge N → `mem_req` high in cycle N+1 → new `instruction` and `ir_valid`=1 after edge N+1.
  - This makes one bubble cycle per instruction.
- Each memory wait cycle adds one cycle of latency.
- A redirect issued during a fetch costs one completed-and-discarded fetch plus one new fetch.

## Test plan
- Reset with `RESET_PC`=16'h0010 and zero-wait memory returning 16'h2F13 → `mem_req` rises one cycle after reset; `instruction`=16'h2F13, `ir_pc`=16'h0010, `ir_valid`=1 one cycle later.
- Three `next_instr` pulses, memory returning 16'h3701, 16'h3F11, 16'h4807 → `mem_addr` goes 16'h0011, 16'h0012, 16'h0013; `ir_pc` tracks each; `ir_valid` drops for exactly one cycle per pulse.
- Memory with 3 wait cycles → `mem_req` and `mem_addr` held constant for 4 cycles; `ir_valid` stays 0 until after the ack.
- `pc_load` with `pc_target`=16'h0200 during a wait-state fetch of 16'h0014 → the word returned for 16'h0014 is discarded; the next request is at 16'h0200; `ir_pc`=16'h0200.
- `pc_load` (target 16'h0300) and `next_instr` in the same HOLD cycle → next fetch is 16'h0300, not `pc`+1; separately, `next_instr` at `pc`=16'hFFFF → next fetch at 16'h0000.
- Assert `reset` while `mem_req`=1 and ack pending, then ack the next cycle → `mem_req`=0, `pc`=`RESET_PC`, `ir_valid`=0; the stale ack does not load the IR.
